// File: rtl/pipeline_defs.sv
// Shared constants for the RV32 pipeline stages.
// Control bundle bit positions and the bubble encoding.
package pipeline_defs;

    localparam int XLEN              = 32;
    localparam int RA_W              = 5;
    localparam int CTRL_W            = 12;
    localparam int CNT_W             = 16;
    localparam int CTRL_MEMREAD_BIT  = 3;
    localparam int CTRL_REGWRITE_BIT = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator between the EX load and the ID consumer.
// Shared with the forwarding unit.
module load_use_detect #(
    parameter int RA_W = 5
) (
    input  logic            valid_ex,
    input  logic            memread_ex,
    input  logic [RA_W-1:0] rd_ex,
    input  logic            valid_id,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic            load_use
);

    logic hit1;
    logic hit2;

    assign hit1 = use_rs1 & (rs1 == rd_ex);
    assign hit2 = use_rs2 & (rs2 == rd_ex);

    // x0 is never really written, so a load to it cannot stall anyone
    assign load_use = valid_ex & memread_ex & (rd_ex != '0)
                    & valid_id & (hit1 | hit2);

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use bubble insertion,
// hold/flush handling and saturating event counters.
module id_ex_pipeline_reg #(
    parameter int XLEN   = pipeline_defs::XLEN,
    parameter int RA_W   = pipeline_defs::RA_W,
    parameter int CTRL_W = pipeline_defs::CTRL_W,
    parameter int CNT_W  = pipeline_defs::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_ID,
    input  logic [XLEN-1:0]   PC_ID,
    input  logic [XLEN-1:0]   Rs1Data_ID,
    input  logic [XLEN-1:0]   Rs2Data_ID,
    input  logic [XLEN-1:0]   Imm_ID,
    input  logic [RA_W-1:0]   Rs1_ID,
    input  logic [RA_W-1:0]   Rs2_ID,
    input  logic [RA_W-1:0]   Rd_ID,
    input  logic              UseRs1_ID,
    input  logic              UseRs2_ID,
    input  logic [CTRL_W-1:0] Ctrl_ID,
    input  logic              Hold,
    input  logic              Flush,
    output logic              Valid_EX,
    output logic [XLEN-1:0]   PC_EX,
    output logic [XLEN-1:0]   Rs1Data_EX,
    output logic [XLEN-1:0]   Rs2Data_EX,
    output logic [XLEN-1:0]   Imm_EX,
    output logic [RA_W-1:0]   Rs1_EX,
    output logic [RA_W-1:0]   Rs2_EX,
    output logic [RA_W-1:0]   Rd_EX,
    output logic [CTRL_W-1:0] Ctrl_EX,
    output logic              Stall_IF_ID,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    import pipeline_defs::*;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    id_ex_t           q;
    id_ex_t           d_id;
    logic             load_use;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] fcnt;

    load_use_detect #(
        .RA_W(RA_W)
    ) u_lud (
        .valid_ex  (q.valid),
        .memread_ex(q.ctrl[CTRL_MEMREAD_BIT]),
        .rd_ex     (q.rd),
        .valid_id  (Valid_ID),
        .use_rs1   (UseRs1_ID),
        .use_rs2   (UseRs2_ID),
        .rs1       (Rs1_ID),
        .rs2       (Rs2_ID),
        .load_use  (load_use)
    );

    assign Stall_IF_ID = (load_use | Hold) & ~Flush;

    always_comb begin
        d_id.valid    = Valid_ID;
        d_id.pc       = PC_ID;
        d_id.rs1_data = Rs1Data_ID;
        d_id.rs2_data = Rs2Data_ID;
        d_id.imm      = Imm_ID;
        d_id.rs1      = Rs1_ID;
        d_id.rs2      = Rs2_ID;
        d_id.rd       = Rd_ID;
        // an empty slot must never carry write enables into EX
        d_id.ctrl     = Valid_ID ? Ctrl_ID : CTRL_NOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= BUBBLE;
            bcnt <= '0;
            fcnt <= '0;
        end else if (Flush) begin
            q <= BUBBLE;
            if (Valid_ID) fcnt <= sat_inc(fcnt);
        end else if (Hold) begin
            q <= q;
        end else if (load_use) begin
            q    <= BUBBLE;
            bcnt <= sat_inc(bcnt);
        end else begin
            q <= d_id;
        end
    end

    assign Valid_EX   = q.valid;
    assign PC_EX      = q.pc;
    assign Rs1Data_EX = q.rs1_data;
    assign Rs2Data_EX = q.rs2_data;
    assign Imm_EX     = q.imm;
    assign Rs1_EX     = q.rs1;
    assign Rs2_EX     = q.rs2;
    assign Rd_EX      = q.rd;
    assign Ctrl_EX    = q.ctrl;
    assign BubbleCnt  = bcnt;
    assign FlushCnt   = fcnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Random and directed stimulus for id_ex_pipeline_reg
// checked against a cycle-level reference model.
module tb_id_ex_pipeline_reg;

    localparam int XLEN   = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;
    localparam int MR     = pipeline_defs::CTRL_MEMREAD_BIT;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              Valid_ID;
    logic [XLEN-1:0]   PC_ID, Rs1Data_ID, Rs2Data_ID, Imm_ID;
    logic [RA_W-1:0]   Rs1_ID, Rs2_ID, Rd_ID;
    logic              UseRs1_ID, UseRs2_ID;
    logic [CTRL_W-1:0] Ctrl_ID;
    logic              Hold, Flush;
    logic              Valid_EX;
    logic [XLEN-1:0]   PC_EX, Rs1Data_EX, Rs2Data_EX, Imm_EX;
    logic [RA_W-1:0]   Rs1_EX, Rs2_EX, Rd_EX;
    logic [CTRL_W-1:0] Ctrl_EX;
    logic              Stall_IF_ID;
    logic [CNT_W-1:0]  BubbleCnt, FlushCnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit              m_valid;
    bit [XLEN-1:0]   m_pc, m_d1, m_d2, m_imm;
    bit [RA_W-1:0]   m_rs1, m_rs2, m_rd;
    bit [CTRL_W-1:0] m_ctrl;
    int              m_bcnt, m_fcnt;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(
        .XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .Valid_ID(Valid_ID),
        .PC_ID(PC_ID), .Rs1Data_ID(Rs1Data_ID),
        .Rs2Data_ID(Rs2Data_ID), .Imm_ID(Imm_ID),
        .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rd_ID(Rd_ID),
        .UseRs1_ID(UseRs1_ID), .UseRs2_ID(UseRs2_ID),
        .Ctrl_ID(Ctrl_ID), .Hold(Hold), .Flush(Flush),
        .Valid_EX(Valid_EX), .PC_EX(PC_EX),
        .Rs1Data_EX(Rs1Data_EX), .Rs2Data_EX(Rs2Data_EX),
        .Imm_EX(Imm_EX), .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX),
        .Rd_EX(Rd_EX), .Ctrl_EX(Ctrl_EX),
        .Stall_IF_ID(Stall_IF_ID),
        .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_in();
        Valid_ID   = ($urandom_range(0, 99) < 85);
        PC_ID      = $urandom;
        Rs1Data_ID = $urandom;
        Rs2Data_ID = $urandom;
        Imm_ID     = $urandom;
        Rs1_ID     = RA_W'($urandom_range(0, 3));
        Rs2_ID     = RA_W'($urandom_range(0, 3));
        Rd_ID      = RA_W'($urandom_range(0, 3));
        UseRs1_ID  = 1'($urandom);
        UseRs2_ID  = 1'($urandom);
        Ctrl_ID    = CTRL_W'($urandom);
    endtask

    task automatic bubble_model();
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    // one clock: check stall before the edge, state after it
    task automatic step();
        bit lu, exp_stall;
        #1;
        lu = m_valid && m_ctrl[MR] && m_rd != 0 && Valid_ID &&
             ((UseRs1_ID && Rs1_ID == m_rd) ||
              (UseRs2_ID && Rs2_ID == m_rd));
        exp_stall = (lu || Hold) && !Flush;
        chk("stall", Stall_IF_ID, exp_stall);
        if (rst) begin
            bubble_model();
            m_bcnt = 0;
            m_fcnt = 0;
        end else if (Flush) begin
            bubble_model();
            if (Valid_ID && m_fcnt < CMAX) m_fcnt++;
        end else if (Hold) begin
            m_valid = m_valid;
        end else if (lu) begin
            bubble_model();
            if (m_bcnt < CMAX) m_bcnt++;
        end else begin
            m_valid = Valid_ID; m_pc = PC_ID;
            m_d1 = Rs1Data_ID; m_d2 = Rs2Data_ID; m_imm = Imm_ID;
            m_rs1 = Rs1_ID; m_rs2 = Rs2_ID; m_rd = Rd_ID;
            m_ctrl = Valid_ID ? Ctrl_ID : '0;
        end
        @(posedge clk);
        #1;
        chk("valid", Valid_EX, m_valid);
        chk("pc", PC_EX, m_pc);
        chk("rs1data", Rs1Data_EX, m_d1);
        chk("rs2data", Rs2Data_EX, m_d2);
        chk("imm", Imm_EX, m_imm);
        chk("rs1", Rs1_EX, m_rs1);
        chk("rs2", Rs2_EX, m_rs2);
        chk("rd", Rd_EX, m_rd);
        chk("ctrl", Ctrl_EX, m_ctrl);
        chk("bcnt", BubbleCnt, m_bcnt);
        chk("fcnt", FlushCnt, m_fcnt);
        @(negedge clk);
    endtask

    task automatic quiet(input bit v);
        rand_in();
        Valid_ID = v; Hold = 0; Flush = 0; rst = 0;
    endtask

    task automatic load_to(input logic [RA_W-1:0] rd);
        quiet(1);
        UseRs1_ID = 0; UseRs2_ID = 0;
        Rd_ID = rd;
        Ctrl_ID[MR] = 1'b1;
        step();
    endtask

    task automatic use_rs2(input logic [RA_W-1:0] r);
        quiet(1);
        Rs2_ID = r; UseRs2_ID = 1;
        Rs1_ID = 0; UseRs1_ID = 0;
        Ctrl_ID[MR] = 1'b0;
    endtask

    initial begin
        bubble_model();
        m_bcnt = 0; m_fcnt = 0;
        rand_in();
        rst = 1; Hold = 0; Flush = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rand_in();
            rst = 1; Hold = 0; Flush = 0;
            step();
        end
        chk("rst_valid", Valid_EX, 1'b0);
        chk("rst_stall", Stall_IF_ID, 1'b0);
        quiet(1);
        step();

        // load-use: one bubble, then the consumer enters EX
        load_to(5);
        use_rs2(5);
        step();
        chk("lu_bubble_valid", Valid_EX, 1'b0);
        chk("lu_bubble_ctrl", Ctrl_EX, 12'h000);
        chk("lu_bcnt", BubbleCnt, 4'd1);
        step();
        chk("lu_rs2_ex", Rs2_EX, 5'd5);
        chk("lu_valid_ex", Valid_EX, 1'b1);

        // x0 load and unused source never stall
        load_to(0);
        use_rs2(0);
        step();
        load_to(7);
        quiet(1);
        Rs1_ID = 7; UseRs1_ID = 0; UseRs2_ID = 0;
        step();
        chk("nostall_bcnt", BubbleCnt, 4'd1);

        // flush beats hold and the hazard
        load_to(6);
        use_rs2(6);
        Hold = 1; Flush = 1;
        step();
        chk("fl_fcnt", FlushCnt, 4'd1);
        chk("fl_bcnt", BubbleCnt, 4'd1);
        chk("fl_valid", Valid_EX, 1'b0);

        // hold freezes a hazard; release gives exactly one bubble
        load_to(9);
        for (int i = 0; i < 3; i++) begin
            use_rs2(9);
            Hold = 1;
            step();
            chk("hold_rd", Rd_EX, 5'd9);
        end
        chk("hold_bcnt", BubbleCnt, 4'd1);
        use_rs2(9);
        step();
        chk("rel_bcnt", BubbleCnt, 4'd2);
        use_rs2(9);
        step();
        chk("rel_enter", Valid_EX, 1'b1);

        // saturation
        for (int i = 0; i < CMAX + 2; i++) begin
            load_to(4);
            use_rs2(4);
            step();
        end
        chk("sat_bcnt", BubbleCnt, 4'hF);

        // random soak
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            Hold  = ($urandom_range(0, 99) < 20);
            Flush = ($urandom_range(0, 99) < 10);
            rst   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1) Ctrl_ID[MR] = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
ID/EX pipeline register for the 5-stage RV32 pipeline, sitting directly upstream of the EX-stage forwarding muxes and ALU.
- Captures decoded operands, register addresses, immediate and control bundle each cycle.
- Performs load-use hazard detection and bubble insertion.
- Supports hold (downstream stall) and flush (branch redirect).
- Keeps saturating bubble/flush event counters for performance debug.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC
RA_W, 5, register address width
CTRL_W, 12, width of opaque EX/MEM/WB control bundle; bit CTRL_MEMREAD_BIT marks loads, bit CTRL_REGWRITE_BIT marks writeback
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
Valid_ID  input  1  ID stage holds a real instruction
PC_ID  input  XLEN  PC of ID instruction
Rs1Data_ID  input  XLEN  register-file read A
Rs2Data_ID  input  XLEN  register-file read B
Imm_ID  input  XLEN  sign-extended immediate
Rs1_ID  input  RA_W  source reg 1 address
Rs2_ID  input  RA_W  source reg 2 address
Rd_ID  input  RA_W  destination address
UseRs1_ID  input  1  instruction reads rs1
UseRs2_ID  input  1  instruction reads rs2
Ctrl_ID  input  CTRL_W  control bundle
Hold  input  1  downstream stall; freeze contents
Flush  input  1  branch/jump redirect; kill ID instruction
Valid_EX  output  1  EX holds a real instruction
PC_EX, Rs1Data_EX, Rs2Data_EX, Imm_EX  output  XLEN each  registered copies (Rs1Data_EX/Rs2Data_EX feed forwarding mux A/B Data_ID inputs)
Rs1_EX, Rs2_EX, Rd_EX  output  RA_W each  registered addresses for the forwarding unit
Ctrl_EX  output  CTRL_W  registered control
Stall_IF_ID  output  1  combinational; freeze PC and IF/ID register
BubbleCnt  output  CNT_W  load-use bubbles inserted
FlushCnt  output  CNT_W  valid instructions killed by Flush

Behaviour:
- Reset (rst=1 at posedge): every registered output is 0, including Valid_EX, Ctrl_EX and both counters. rst overrides all other inputs.
- Hazard detection, all combinational:
  - load_use = Valid_EX & Ctrl_EX[CTRL_MEMREAD_BIT] & (Rd_EX != 0) & Valid_ID & ((UseRs1_ID & Rs1_ID==Rd_EX) | (UseRs2_ID & Rs2_ID==Rd_EX)).
  - Stall_IF_ID = (load_use | Hold) & ~Flush.
- Per-posedge update, in priority order:
  1. rst: clear all.
  2. Flush: load bubble, i.e. Valid_EX=0, Ctrl_EX=0, all data and address fields 0. Applies even when Hold=1. FlushCnt increments if Valid_ID=1.
  3. Hold: all registers keep value. No bubble is inserted and BubbleCnt does not increment, even if load_use=1.
  4. load_use: load bubble (same values as Flush). BubbleCnt increments.
  5. Otherwise: load all *_ID fields. Valid_EX=Valid_ID. If Valid_ID=0, Ctrl_EX is forced to 0.
- Latency: exactly 1 cycle ID to EX. A load followed by a dependent instruction costs exactly 1 bubble. The dependent instruction enters EX in the cycle after the bubble and gets its operand via the MEM/WB forwarding path.
- x0 rule: a load with Rd_EX=0 never triggers load_use.
- Counters saturate at all-ones; no wrap.
- A bubble never asserts a write: Ctrl_EX=0 guarantees RegWrite=0 and MemWrite=0.
- Reset mid-stall: after rst the pipeline is empty, so Stall_IF_ID deasserts in the same cycle once Valid_EX=0.

Decomposition:
- Shared package/header pipeline_defs: XLEN, RA_W, CTRL_W, CTRL_MEMREAD_BIT, CTRL_REGWRITE_BIT, bubble constant CTRL_NOP = 0.
- One natural sub-module: load_use_detect (purely combinational comparator producing load_use). The forwarding unit reuses it.
- Counters are inline: one shared saturating-increment function, no separate module.

Test Plan:
- Reset: hold rst=1 two cycles with random ID inputs -> all outputs 0, Stall_IF_ID=0; first posedge after release loads the ID fields.
- Load-use: lw x5 in EX (MemRead=1, Rd_EX=5), ID add with Rs2_ID=5, UseRs2=1 -> Stall_IF_ID=1; next cycle Valid_EX=0, Ctrl_EX=0, BubbleCnt=1; following cycle the add enters EX with Rs2_EX=5.
- x0 and unused source: lw x0, or Rs1_ID match with UseRs1_ID=0 -> no stall, BubbleCnt unchanged.
- Flush during hazard plus Hold: load_use=1, Hold=1, Flush=1, Valid_ID=1 -> Stall_IF_ID=0; next cycle bubble loaded, FlushCnt=1, BubbleCnt=0.
- Hold with hazard: Hold=1 for 3 cycles while load_use=1 -> EX outputs constant, BubbleCnt unchanged; on Hold release exactly one bubble is inserted.
- Saturation: preload via 2^CNT_W-1 hazards (or force) then one more -> BubbleCnt stays 16'hFFFF.
